// File: rtl/plic_claim_arb_if.sv
// rtl/plic_claim_arb_if.sv - claim/complete register-bus handshake into the arbiter
interface plic_claim_arb_if #(
  parameter int IDW = 6
);
  logic           claim_req;
  logic           complete_req;
  logic [IDW-1:0] complete_id;
  logic [IDW-1:0] claim_id;
  logic           claim_vld;

  modport master (
    output claim_req, complete_req, complete_id,
    input  claim_id, claim_vld
  );

  modport slave (
    input  claim_req, complete_req, complete_id,
    output claim_id, claim_vld
  );
endinterface

// File: rtl/plic_claim_arb.sv
// rtl/plic_claim_arb.sv - sequential priority scan, live-masked irq and claim/complete tracking
module plic_claim_arb #(
  parameter int N_SRC = 64,
  parameter int PW    = 5,
  parameter int IDW   = 6
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [N_SRC-1:0]    ip,
  input  logic [N_SRC-1:0]    ie,
  input  logic [N_SRC*PW-1:0] prio,
  input  logic [PW-1:0]       thres,
  plic_claim_arb_if.slave     bus,
  output logic                irq,
  output logic [N_SRC-1:0]    inflight
);
  localparam int             NP       = 1 << IDW;
  localparam logic [IDW-1:0] FIRST_ID = IDW'(1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N_SRC - 1);

  typedef enum logic {SCAN, COMMIT} phase_t;
  localparam phase_t START_PH = (N_SRC == 2) ? COMMIT : SCAN;

  phase_t         phase;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] run_id;
  logic [PW-1:0]  run_pr;
  logic [IDW-1:0] cm_id;
  logic [PW-1:0]  cm_pr;

  logic [NP-1:0]    elig_vec;
  logic [NP*PW-1:0] prio_p;
  logic [PW-1:0]    idx_pr;
  logic             take_idx;
  logic [IDW-1:0]   fold_id;
  logic [PW-1:0]    fold_pr;
  logic [IDW-1:0]   eff_id;
  logic [N_SRC-1:0] infl_nxt;

  // Vectors are padded to the full ID space so any IDW-wide index stays in range.
  always_comb begin
    elig_vec = '0;
    prio_p   = '0;
    prio_p[N_SRC*PW-1:0] = prio;
    for (int k = 0; k < N_SRC; k++)
      elig_vec[k] = (k != 0) && ip[k] && ie[k] && !inflight[k] && (prio[k*PW +: PW] != '0);
  end

  assign idx_pr   = prio_p[int'(idx)*PW +: PW];
  assign take_idx = elig_vec[idx] && (idx_pr > run_pr);
  assign fold_id  = take_idx ? idx : run_id;
  assign fold_pr  = take_idx ? idx_pr : run_pr;

  // Committed winner is re-qualified every cycle so irq drops as soon as it stops being valid.
  assign eff_id = ((cm_id != '0) && elig_vec[cm_id] && (cm_pr > thres)) ? cm_id : '0;
  assign irq    = (eff_id != '0);

  // Complete clears first, claim sets afterwards: a same-ID claim wins.
  always_comb begin
    infl_nxt = inflight;
    for (int k = 1; k < N_SRC; k++) begin
      if (bus.complete_req && (bus.complete_id == IDW'(k)))
        infl_nxt[k] = 1'b0;
      if (bus.claim_req && (eff_id == IDW'(k)))
        infl_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      phase         <= START_PH;
      idx           <= FIRST_ID;
      run_id        <= '0;
      run_pr        <= '0;
      cm_id         <= '0;
      cm_pr         <= '0;
      inflight      <= '0;
      bus.claim_id  <= '0;
      bus.claim_vld <= 1'b0;
    end else begin
      inflight      <= infl_nxt;
      bus.claim_vld <= bus.claim_req && (eff_id != '0);
      if (bus.claim_req)
        bus.claim_id <= eff_id;

      if (bus.claim_req || bus.complete_req) begin
        phase  <= START_PH;
        idx    <= FIRST_ID;
        run_id <= '0;
        run_pr <= '0;
        if (bus.claim_req) begin
          cm_id <= '0;
          cm_pr <= '0;
        end
      end else if (phase == COMMIT) begin
        cm_id  <= fold_id;
        cm_pr  <= fold_pr;
        run_id <= '0;
        run_pr <= '0;
        idx    <= FIRST_ID;
        phase  <= START_PH;
      end else begin
        run_id <= fold_id;
        run_pr <= fold_pr;
        idx    <= idx + FIRST_ID;
        phase  <= ((idx + FIRST_ID) == LAST_ID) ? COMMIT : SCAN;
      end
    end
  end
endmodule

// File: doc/plic_claim_arb.md
Name: plic_claim_arb

Overview:
- Sequential priority arbiter and claim/complete controller for the platform-level interrupt block.
- Scans the gateway pending vector, enables and per-source priorities, keeps the highest-priority eligible source, and drives the external interrupt line to the hart.
- Serves bus-side claim reads and complete writes.
- Tracks which sources are in service so the gateways hold off re-arming them.

Parameters:
- N_SRC, 64, number of interrupt sources including reserved source 0 (legal range 2..64).
- PW, 5, priority/threshold width in bits.
- IDW, 6, ID width (must satisfy 2^IDW >= N_SRC).

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  asynchronous active-low reset.
- ip  input  N_SRC  gateway pending bits; bit 0 ignored.
- ie  input  N_SRC  enable bits; bit 0 ignored.
- prio  input  N_SRC*PW  flat priorities; source k at [k*PW +: PW].
- thres  input  PW  global threshold.
- claim_req  input  1  one-cycle claim strobe (bus read of claim register).
- complete_req  input  1  one-cycle complete strobe.
- complete_id  input  IDW  ID being completed.
- claim_id  output  IDW  ID returned to the bus on claim; 0 means none.
- claim_vld  output  1  pulses with claim_id when a nonzero ID is granted.
- irq  output  1  external interrupt request to the hart.
- inflight  output  N_SRC  claimed-not-completed mask, fed to the gateways.

Behaviour:
- Reset (async): idx=1, run_id=0, run_pr=0, cm_id=0, cm_pr=0, inflight=0, claim_id=0, claim_vld=0. irq is therefore 0 through reset.
- Eligibility of source k: ip[k] & ie[k] & !inflight[k] & prio[k]!=0.
- Scan FSM:
  - States are SCAN and COMMIT, implemented as the counter idx (1..N_SRC-1) plus a commit flag.
  - In SCAN, one source is evaluated per cycle. If source idx is eligible and prio[idx] > run_pr (strictly greater), then run_id<=idx and run_pr<=prio[idx].
  - Ties therefore go to the lowest ID.
  - When idx==N_SRC-1, that source's result is folded in, then cm_id/cm_pr <= the final run result. Next cycle run is cleared and idx wraps to 1.
  - Sweep period is N_SRC-1 cycles; the scan runs continuously.
- Live masking of the committed result: eff_id = cm_id if cm_id!=0, the source is still eligible, and cm_pr > thres; otherwise 0.
- irq is combinational: (eff_id!=0).
  - irq falls in the same cycle that the winner's ip/ie drops or thres is raised.
  - irq rises only after the next commit, at most 2*(N_SRC-1) cycles after the source becomes eligible.
- Claim (claim_req=1):
  - Next cycle: claim_id<=eff_id and claim_vld<=(eff_id!=0).
  - If eff_id!=0, inflight[eff_id] is set at the same edge.
  - cm_id/cm_pr are cleared and the scan restarts at idx=1 with run cleared, so the claimed source is not granted twice.
  - If eff_id==0: claim_id<=0, claim_vld<=0, no state change beyond the restart.
  - claim_id holds its value until the next claim; claim_vld is a 1-cycle pulse.
- Complete (complete_req=1):
  - inflight[complete_id] is cleared at the next edge, and the scan restarts.
  - complete_id of 0, complete_id >= N_SRC, or an ID not currently in flight is ignored, apart from the restart.
- Simultaneous claim and complete in one cycle: both take effect at the same edge.
  - The claim uses the pre-edge eff_id.
  - If the completed ID equals the claimed ID, the bit ends set: the claim wins.
- thres/prio/ie changes mid-sweep need no restart; they are picked up by the live mask and the next sweep.
- Reset asserted mid-sweep: all state returns to reset values immediately, and inflight is fully cleared.

Test Plan:
- N_SRC=8, thres=0, prio[3]=2, ip[3]=ie[3]=1 from reset release → irq=1 within 14 cycles.
  - Then claim_req → next cycle claim_id=3, claim_vld=1, inflight=8'h08, irq=0.
  - A second claim → claim_id=0, claim_vld=0.
- Sources 2 and 5 eligible, prio[2]=4, prio[5]=4 → claim returns 2 (tie to lower ID).
  - Then prio[5]=6 and another claim after one sweep → claim returns 5.
- Source 4 prio 3, thres=3 → irq stays 0 over 3 sweeps and claim returns 0.
  - Set thres=2 → irq=1 after the next commit (≤14 cycles).
- Claim source 6, assert complete_req with complete_id=6 → inflight[6]=0.
  - With ip[6] still 1, irq reasserts within 14 cycles.
  - complete_id=0 and complete_id=7 (not in flight) → inflight unchanged.
- Sources 1 and 2 in flight; same cycle: claim_req (eff_id=3) and complete_req (complete_id=1) → inflight becomes 8'h0C. Also: claim of 3 together with complete_id=3 → inflight[3]=1.
- Drop HRESETn mid-sweep with inflight=8'h06 → claim_id=0, irq=0, inflight=0 asynchronously, and scanning restarts from idx=1 on release.
